// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA timing generator.
// Holds the default 640x480@60 geometry, the counter widths and the helper that
// derives a full line/frame length from its four segments.
package vga_timing_pkg;

  localparam int unsigned X_W   = 11;  // CounterX width
  localparam int unsigned Y_W   = 10;  // CounterY width
  localparam int unsigned DIV_W = 3;   // pixel divider width, CLK_DIV up to 8

  localparam int unsigned CLK_DIV_DEF  = 2;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Total length of one axis: visible + front porch + sync + back porch.
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL_DEF = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL_DEF = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle between the VGA timing generator and its consumer.
//   vga_en        : run enable from the consumer side
//   pix_en        : one-clk pixel strobe
//   CounterX/Y    : current pixel / line position
//   inDisplayArea : position is in the visible region
//   vga_h_sync/v  : sync outputs
//   line_start    : pulse when CounterX wraps to 0
//   frame_start   : pulse when the position wraps to (0,0)
// master = generator side, slave = consumer side.
interface vga_timing_gen_if;

  logic                         vga_en;
  logic                         pix_en;
  logic [vga_timing_pkg::X_W-1:0] CounterX;
  logic [vga_timing_pkg::Y_W-1:0] CounterY;
  logic                         inDisplayArea;
  logic                         vga_h_sync;
  logic                         vga_v_sync;
  logic                         line_start;
  logic                         frame_start;

  modport master (
    input  vga_en,
    output pix_en, CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync, line_start,
           frame_start
  );

  modport slave (
    output vga_en,
    input  pix_en, CounterX, CounterY, inDisplayArea, vga_h_sync, vga_v_sync, line_start,
           frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical) of the VGA generator.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr         : synchronous clear to 0 (timing idle)
//   step        : advance by one this clk
//   wrap_count  : axis length; count wraps from wrap_count-1 to 0
//   sync_start/sync_stop : sync window [start, stop)
//   active_lim  : visible positions are count < active_lim
//   count       : registered position
//   wrap        : step taken at the last position (count returns to 0 next clk)
//   in_sync/in_active : decoded from the next-state count so a registered copy
//                       lines up with count
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Width = X_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [Width-1:0] wrap_count,
  input  logic [Width-1:0] sync_start,
  input  logic [Width-1:0] sync_stop,
  input  logic [Width-1:0] active_lim,
  output logic [Width-1:0] count,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_active
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  assign wrap = step && (count_q == wrap_count - One);

  always_comb begin
    count_d = count_q;
    if (clr || wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign in_sync   = (count_d >= sync_start) && (count_d < sync_stop);
  assign in_active = (count_d < active_lim);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: divides clk down to a pixel strobe and walks a
// (CounterX, CounterY) raster, producing syncs, display-area flag and
// line/frame start pulses. All outputs are registered and change together.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : vga_timing_gen_if.master (vga_en in, all timing signals out)
// With vga_en low the raster is held at (0,0), strobes and the display flag
// are 0 and both syncs are inactive; re-enabling behaves like reset release.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_ACT = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  vga_timing_gen_if.master bus
);

  localparam int unsigned      H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned      V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             run, tick, h_step;
  logic [X_W-1:0]   h_count;
  logic [Y_W-1:0]   v_count;
  logic             h_wrap, h_in_sync, h_in_active;
  logic             v_wrap, v_in_sync, v_in_active;
  logic             pix_en_q, line_start_q, frame_start_q, disp_q, h_sync_q, v_sync_q;

  assign run    = bus.vga_en;
  assign tick   = (div_q == DIV_LAST);
  // Raster moves on the same edge that raises pix_en, so the strobe and the
  // new position appear in the same clk.
  assign h_step = run && tick;

  always_comb begin
    div_d = '0;
    if (run && !tick) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  vga_axis_counter #(
    .Width(X_W)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!run),
    .step      (h_step),
    .wrap_count(X_W'(H_TOTAL)),
    .sync_start(X_W'(H_ACTIVE + H_FP)),
    .sync_stop (X_W'(H_ACTIVE + H_FP + H_SYNC)),
    .active_lim(X_W'(H_ACTIVE)),
    .count     (h_count),
    .wrap      (h_wrap),
    .in_sync   (h_in_sync),
    .in_active (h_in_active)
  );

  vga_axis_counter #(
    .Width(Y_W)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!run),
    .step      (h_wrap),
    .wrap_count(Y_W'(V_TOTAL)),
    .sync_start(Y_W'(V_ACTIVE + V_FP)),
    .sync_stop (Y_W'(V_ACTIVE + V_FP + V_SYNC)),
    .active_lim(Y_W'(V_ACTIVE)),
    .count     (v_count),
    .wrap      (v_wrap),
    .in_sync   (v_in_sync),
    .in_active (v_in_active)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      disp_q        <= 1'b0;
      h_sync_q      <= ~SYNC_ACT;
      v_sync_q      <= ~SYNC_ACT;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= h_step;
      line_start_q  <= h_wrap;
      // v_wrap already implies h_wrap: the position returns to (0,0).
      frame_start_q <= v_wrap;
      disp_q        <= run && h_in_active && v_in_active;
      h_sync_q      <= (run && h_in_sync) ? SYNC_ACT : ~SYNC_ACT;
      v_sync_q      <= (run && v_in_sync) ? SYNC_ACT : ~SYNC_ACT;
    end
  end

  assign bus.pix_en        = pix_en_q;
  assign bus.CounterX      = h_count;
  assign bus.CounterY      = v_count;
  assign bus.inDisplayArea = disp_q;
  assign bus.vga_h_sync    = h_sync_q;
  assign bus.vga_v_sync    = v_sync_q;
  assign bus.line_start    = line_start_q;
  assign bus.frame_start   = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- CLK_DIV, 2, clk cycles per pixel (1..8).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_ACT, 0, active level of both sync outputs.

REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- vga_en, in, 1, run enable; low holds timing idle.
- pix_en, out, 1, one-clk pixel strobe.
- CounterX, out, 11, horizontal pixel position.
- CounterY, out, 10, vertical line position.
- inDisplayArea, out, 1, inside the visible region.
- vga_h_sync, out, 1, horizontal sync.
- vga_v_sync, out, 1, vertical sync.
- line_start, out, 1, one-clk pulse when CounterX wraps to 0.
- frame_start, out, 1, one-clk pulse when (CounterX, CounterY) becomes (0,0).

Function
REQ-004 H_TOTAL SHALL equal H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL SHALL equal V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
REQ-005 The divider SHALL count 0..CLK_DIV-1 while vga_en=1; pix_en SHALL be 1 for exactly the clk in which the divider equals CLK_DIV-1; CLK_DIV=1 SHALL give pix_en continuously high.
REQ-006 CounterX SHALL advance only on pix_en and wrap from H_TOTAL-1 to 0.
REQ-007 CounterY SHALL advance only on pix_en when CounterX=H_TOTAL-1, and wrap from V_TOTAL-1 to 0.
REQ-008 All outputs SHALL be registered, and sync/display outputs SHALL be decoded from next-state counters so they align with CounterX/CounterY in the same clk.
REQ-009 vga_h_sync SHALL equal SYNC_ACT iff H_ACTIVE+H_FP <= CounterX < H_ACTIVE+H_FP+H_SYNC; otherwise it SHALL equal ~SYNC_ACT.
REQ-010 vga_v_sync SHALL equal SYNC_ACT iff V_ACTIVE+V_FP <= CounterY < V_ACTIVE+V_FP+V_SYNC, with no dependence on CounterX.
REQ-011 inDisplayArea SHALL be 1 iff CounterX < H_ACTIVE and CounterY < V_ACTIVE.
REQ-012 line_start SHALL pulse for one clk in the clk where CounterX becomes 0; frame_start SHALL pulse in the same clk when CounterY also becomes 0.
REQ-013 When vga_en is low in any clk (mid-line or mid-frame), the divider, CounterX and CounterY SHALL clear to 0 on the next clk, and pix_en, line_start, frame_start and inDisplayArea SHALL be 0 while vga_en stays low.
- Both syncs SHALL be ~SYNC_ACT while vga_en stays low.
REQ-014 On vga_en rising, the first pix_en SHALL occur CLK_DIV clks later.
- That pix_en SHALL move CounterX to 1, with no frame_start emitted for the (0,0) held position.

Reset
REQ-015 While rst_n=0, the following SHALL hold asynchronously:
- the divider, CounterX and CounterY SHALL be 0;
- pix_en, line_start, frame_start and inDisplayArea SHALL be 0;
- vga_h_sync and vga_v_sync SHALL be ~SYNC_ACT.
REQ-016 Release of rst_n SHALL be treated identically to a vga_en rising edge per REQ-014.

Structure
REQ-017 The default timing constants, the H_TOTAL/V_TOTAL derivations and the counter widths SHALL live in the shared package vga_timing_pkg.
REQ-018 One sub-module, vga_axis_counter, SHALL be used, instantiated twice (H and V).
- Ports: step, wrap-count, sync window and active limit.
- Outputs: count, wrap pulse, sync and active flags.

Verification
REQ-019 The bench SHALL cover at least these scenarios:
- Defaults, free run 2 frames: pix_en period 2 clk; 800 pix_en per line_start; 525 line_start per frame_start; frame_start period 840000 clk.
- Defaults: vga_h_sync low for exactly 96 pix_en, starting at CounterX=656; vga_v_sync low for exactly 2 lines starting at CounterY=490.
- inDisplayArea is 1 at (639,479) and 0 at (640,0) and (0,480); exactly 307200 active pixels per frame.
- CLK_DIV=1, SYNC_ACT=1: pix_en constantly high; vga_h_sync high for CounterX 656..751.
- vga_en dropped at CounterX=300, CounterY=200 for 5 clk: counters 0 and syncs ~SYNC_ACT on the next clk; first pix_en 2 clk after re-enable; CounterX=1 after it.
- rst_n asserted mid-vsync: outputs reach reset values with no clk edge required; after release, timing repeats the first-frame sequence exactly.
